// File: rtl/spi_io_ctrl_pkg.sv
// Shared definitions for the PCMCIA-mapped SPI master: register map, control
// bit positions, sequencer states and the STATUS register layout.
package spi_io_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;

  localparam int CTRL_OVR_CLR   = 3;
  localparam int CTRL_IE        = 4;
  localparam int CTRL_SSEN      = 5;
  localparam int CTRL_TXOVR_CLR = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } spi_state_e;

  // Field order matches STATUS bits 6..0
  typedef struct packed {
    logic txovr;
    logic ssen;
    logic ie;
    logic ovr;
    logic rxv;
    logic txf;
    logic busy;
  } spi_status_t;

  function automatic logic [7:0] pack_status(input spi_status_t s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/spi_io_ctrl_clk_div.sv
// SCLK half-period timer: counts while enabled, pulses tick when the count
// reaches the latched divider and restarts from zero.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div_lat,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div_lat);

  always_ff @(posedge gclk) begin
    if (!grst_n || load || tick) cnt <= '0;
    else if (en)                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_io_ctrl.sv
// Byte-wide mode-0 SPI master behind the I/O window: register file, one-deep
// TX holding buffer and the bit sequencer that drives SCLK/MOSI.
module spi_io_ctrl
  import spi_io_ctrl_pkg::*;
#(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       WR_STB,
  input  logic       RD_STB,
  output logic [7:0] RDATA,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       INT
);

  spi_state_e       state;
  logic             busy, txf, rxv, ovr, txovr, ie, ssen;
  logic [DIV_W-1:0] div, div_lat;
  logic [7:0]       hold, shreg, rx_reg;
  logic             rx_bit;
  logic [2:0]       bitcnt;
  logic             sclk, mosi;
  logic             tick, byte_done;
  spi_status_t      st;

  logic wr_data, wr_ctrl, wr_div, rd_data;
  assign wr_data = WR_STB && (ADDR == ADDR_DATA);
  assign wr_ctrl = WR_STB && (ADDR == ADDR_CTRL);
  assign wr_div  = WR_STB && (ADDR == ADDR_DIV);
  assign rd_data = RD_STB && (ADDR == ADDR_DATA);

  // The received byte is committed on the tick that drops SCLK after bit 7,
  // so the DONE state that follows is purely the inter-byte gap cycle.
  assign byte_done = (state == S_HIGH) && tick && (bitcnt == 3'd7);

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .gclk    (CLK),
    .grst_n  (RESET),
    .load    (state == S_LOAD),
    .en      ((state == S_LOW) || (state == S_HIGH)),
    .div_lat (div_lat),
    .tick    (tick)
  );

  // Register file; where a set and a clear meet in one cycle the set wins.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      txf   <= 1'b0;
      rxv   <= 1'b0;
      ovr   <= 1'b0;
      txovr <= 1'b0;
      ie    <= 1'b0;
      ssen  <= 1'b0;
      div   <= DIV_RST;
      hold  <= '0;
    end else begin
      if (wr_ctrl) begin
        ie   <= WDATA[CTRL_IE];
        ssen <= WDATA[CTRL_SSEN];
        if (WDATA[CTRL_OVR_CLR])   ovr   <= 1'b0;
        if (WDATA[CTRL_TXOVR_CLR]) txovr <= 1'b0;
      end
      if (wr_div) div <= DIV_W'(WDATA);

      if (state == S_LOAD) txf <= 1'b0;
      if (wr_data) begin
        if (txf && (state != S_LOAD)) begin
          txovr <= 1'b1;
        end else begin
          hold <= WDATA;
          txf  <= 1'b1;
        end
      end

      if (rd_data) rxv <= 1'b0;
      if (byte_done) begin
        rxv <= 1'b1;
        if (rxv && !rd_data) ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      shreg   <= '0;
      rx_bit  <= 1'b0;
      rx_reg  <= '0;
      bitcnt  <= '0;
      div_lat <= DIV_RST;
    end else begin
      unique case (state)
        S_IDLE: if (txf) state <= S_LOAD;
        S_LOAD: begin
          shreg   <= hold;
          busy    <= 1'b1;
          div_lat <= div;
          mosi    <= hold[7];
          bitcnt  <= '0;
          state   <= S_LOW;
        end
        S_LOW: if (tick) begin
          sclk   <= 1'b1;
          rx_bit <= MISO;
          state  <= S_HIGH;
        end
        S_HIGH: if (tick) begin
          sclk <= 1'b0;
          if (bitcnt != 3'd7) begin
            shreg  <= {shreg[6:0], rx_bit};
            mosi   <= shreg[6];
            bitcnt <= bitcnt + 3'd1;
            state  <= S_LOW;
          end else begin
            rx_reg <= {shreg[6:0], rx_bit};
            busy   <= 1'b0;
            mosi   <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= txf ? S_LOAD : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign st = '{txovr: txovr, ssen: ssen, ie: ie, ovr: ovr,
                rxv: rxv, txf: txf, busy: busy};

  always_comb begin
    RDATA = '0;
    unique case (ADDR)
      ADDR_DATA: RDATA = rx_reg;
      ADDR_CTRL: RDATA = pack_status(st);
      ADDR_DIV:  RDATA = 8'(div);
      default:   RDATA = '0;
    endcase
  end

  assign SS   = ~ssen;
  assign SCLK = sclk;
  assign MOSI = mosi;
  assign INT  = ie & rxv;

endmodule
